// File: rtl/edge_event_arbiter.sv
// Falling-edge event scheduler: per-channel edge capture into a pending latch,
// with round-robin arbitration onto a single valid/ready event port.
module edge_event_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    level,
  input  logic [N-1:0]    enable,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [ID_W-1:0] evt_id,
  output logic [N-1:0]    overflow,
  input  logic            ovf_clr
);

  // Handshake: evt_valid/evt_id are offered from OFFER and held until an edge
  // where evt_valid & evt_ready are both 1; that edge transfers the event.
  localparam logic [0:0] STATE_IDLE  = 1'b0;
  localparam logic [0:0] STATE_OFFER = 1'b1;

  logic [0:0]      state;
  logic [N-1:0]    prev;
  logic [N-1:0]    pending;
  logic [ID_W-1:0] rr_ptr;

  logic [N-1:0]    fall;
  logic [N-1:0]    capture;
  logic [N-1:0]    clr;
  logic [N-1:0]    ovf_set;
  logic            found;
  logic [ID_W-1:0] winner;
  int              idx;

  assign fall      = prev & ~level;
  assign capture   = fall & enable;
  assign evt_valid = (state == STATE_OFFER);

  always_comb begin
    clr = '0;
    if (state == STATE_OFFER && evt_ready) clr[evt_id] = 1'b1;
  end

  // A capture on the accept edge of the same channel is a fresh event, not an overflow.
  assign ovf_set = capture & pending & ~clr;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!found && pending[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= STATE_IDLE;
      prev     <= '0;
      pending  <= '0;
      overflow <= '0;
      rr_ptr   <= ID_W'(N - 1);
      evt_id   <= '0;
    end else begin
      prev     <= level;
      pending  <= (pending & ~clr) | capture;
      overflow <= (overflow & ~{N{ovf_clr}}) | ovf_set;
      case (state)
        STATE_IDLE: begin
          if (found) begin
            evt_id <= winner;
            state  <= STATE_OFFER;
          end
        end
        STATE_OFFER: begin
          if (evt_ready) begin
            rr_ptr <= evt_id;
            state  <= STATE_IDLE;
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed vector bench for edge_event_arbiter: one table of per-cycle inputs
// and expected outputs, plus a bounded round-robin burst sequence.
module tb_edge_event_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] level;
  logic [3:0] enable;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [3:0] overflow;
  logic       ovf_clr;

  int total = 0;
  int bad   = 0;

  edge_event_arbiter #(.N(4), .ID_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .level     (level),
    .enable    (enable),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic [3:0] lvl;
    logic [3:0] en;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [1:0] id;
    logic [3:0] ovf;
    string      tag;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] exp_q[$];

  function automatic void add(input logic rst, input logic [3:0] lvl, input logic [3:0] en,
                              input logic rdy, input logic clr, input logic ev,
                              input logic [1:0] id, input logic [3:0] ovf, input string tag);
    vec_t v;
    v.rst = rst; v.lvl = lvl; v.en = en; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.id = id; v.ovf = ovf; v.tag = tag;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // driver: apply inputs, take one rising edge, sample 1 time unit later
  task automatic drive_cycle(input logic rst, input logic [3:0] lvl, input logic [3:0] en,
                             input logic rdy, input logic clr);
    reset = rst; level = lvl; enable = en; evt_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cycles;
    // reset + single event
    add(1, 4'hF, 4'hF, 0, 0, 0, 0, 4'h0, "reset");
    add(0, 4'hF, 4'hF, 0, 0, 0, 0, 4'h0, "post_reset");
    add(0, 4'hF, 4'hF, 0, 0, 0, 0, 4'h0, "idle_high");
    add(0, 4'hE, 4'hF, 1, 0, 0, 0, 4'h0, "single_pending");
    add(0, 4'hE, 4'hF, 1, 0, 1, 0, 4'h0, "single_offer");
    add(0, 4'hE, 4'hF, 1, 0, 0, 0, 4'h0, "single_accept");
    add(0, 4'hF, 4'hF, 1, 0, 0, 0, 4'h0, "single_rise");
    // round robin, all four on one edge
    add(1, 4'hF, 4'hF, 1, 0, 0, 0, 4'h0, "rr_reset");
    add(0, 4'hF, 4'hF, 1, 0, 0, 0, 4'h0, "rr_prime");
    add(0, 4'h0, 4'hF, 1, 0, 0, 0, 4'h0, "rr_capture");
    add(0, 4'h0, 4'hF, 1, 0, 1, 0, 4'h0, "rr_id0");
    add(0, 4'h0, 4'hF, 1, 0, 0, 0, 4'h0, "rr_bubble0");
    add(0, 4'h0, 4'hF, 1, 0, 1, 1, 4'h0, "rr_id1");
    add(0, 4'h0, 4'hF, 1, 0, 0, 1, 4'h0, "rr_bubble1");
    add(0, 4'h0, 4'hF, 1, 0, 1, 2, 4'h0, "rr_id2");
    add(0, 4'h0, 4'hF, 1, 0, 0, 2, 4'h0, "rr_bubble2");
    add(0, 4'h0, 4'hF, 1, 0, 1, 3, 4'h0, "rr_id3");
    add(0, 4'h0, 4'hF, 1, 0, 0, 3, 4'h0, "rr_bubble3");
    add(0, 4'h0, 4'hF, 1, 0, 0, 3, 4'h0, "rr_drained");
    // channels 1 and 3 again with rr_ptr=3
    add(0, 4'hF, 4'hF, 1, 0, 0, 3, 4'h0, "rr2_rise");
    add(0, 4'h5, 4'hF, 1, 0, 0, 3, 4'h0, "rr2_capture");
    add(0, 4'h5, 4'hF, 1, 0, 1, 1, 4'h0, "rr2_id1");
    add(0, 4'h5, 4'hF, 1, 0, 0, 1, 4'h0, "rr2_bubble");
    add(0, 4'h5, 4'hF, 1, 0, 1, 3, 4'h0, "rr2_id3");
    add(0, 4'h5, 4'hF, 1, 0, 0, 3, 4'h0, "rr2_done");
    // backpressure + overflow on channel 2
    add(0, 4'h1, 4'hF, 0, 0, 0, 3, 4'h0, "bp_capture");
    add(0, 4'h1, 4'hF, 0, 0, 1, 2, 4'h0, "bp_offer");
    add(0, 4'h5, 4'hF, 0, 0, 1, 2, 4'h0, "bp_hold_rise");
    add(0, 4'h1, 4'hF, 0, 0, 1, 2, 4'h4, "bp_overflow");
    add(0, 4'h1, 4'hF, 1, 0, 0, 2, 4'h4, "bp_accept");
    add(0, 4'h1, 4'hF, 1, 0, 0, 2, 4'h4, "bp_one_event");
    add(0, 4'h1, 4'hF, 1, 1, 0, 2, 4'h0, "ovf_clear");
    // fall coincident with accept
    add(0, 4'h3, 4'hF, 0, 0, 0, 2, 4'h0, "co_rise");
    add(0, 4'h1, 4'hF, 0, 0, 0, 2, 4'h0, "co_capture");
    add(0, 4'h3, 4'hF, 0, 0, 1, 1, 4'h0, "co_offer");
    add(0, 4'h1, 4'hF, 1, 0, 0, 1, 4'h0, "co_accept_fall");
    add(0, 4'h1, 4'hF, 0, 0, 1, 1, 4'h0, "co_second_offer");
    add(0, 4'h1, 4'hF, 1, 0, 0, 1, 4'h0, "co_second_accept");
    // enable gating on channel 3
    add(0, 4'h9, 4'h7, 0, 0, 0, 1, 4'h0, "en_rise");
    add(0, 4'h1, 4'h7, 0, 0, 0, 1, 4'h0, "en_masked_fall");
    add(0, 4'h1, 4'h7, 0, 0, 0, 1, 4'h0, "en_no_event");
    add(0, 4'h9, 4'hF, 0, 0, 0, 1, 4'h0, "en_rise2");
    add(0, 4'h1, 4'hF, 0, 0, 0, 1, 4'h0, "en_capture");
    add(0, 4'h1, 4'h7, 0, 0, 1, 3, 4'h0, "en_disabled_offer");
    add(0, 4'h1, 4'h7, 1, 0, 0, 3, 4'h0, "en_disabled_accept");
    // reset while offering with another channel pending
    add(0, 4'h5, 4'hF, 0, 0, 0, 3, 4'h0, "rs_rise");
    add(0, 4'h0, 4'hF, 0, 0, 0, 3, 4'h0, "rs_capture");
    add(0, 4'h0, 4'hF, 0, 0, 1, 0, 4'h0, "rs_offer");
    add(1, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, "rs_reset");
    add(0, 4'h0, 4'hF, 1, 0, 0, 0, 4'h0, "rs_low_after");
    add(0, 4'h0, 4'hF, 1, 0, 0, 0, 4'h0, "rs_no_event1");
    add(0, 4'h0, 4'hF, 1, 0, 0, 0, 4'h0, "rs_no_event2");
    // overflow set beats ovf_clr, then reset clears overflow
    add(0, 4'h1, 4'hF, 0, 0, 0, 0, 4'h0, "sw_rise");
    add(0, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, "sw_capture");
    add(0, 4'h0, 4'hF, 0, 0, 1, 0, 4'h0, "sw_offer");
    add(0, 4'h1, 4'hF, 0, 0, 1, 0, 4'h0, "sw_rise2");
    add(0, 4'h0, 4'hF, 0, 1, 1, 0, 4'h1, "sw_set_wins");
    add(0, 4'h0, 4'hF, 0, 0, 1, 0, 4'h1, "sw_sticky");
    add(1, 4'h1, 4'hF, 0, 0, 0, 0, 4'h0, "sw_reset");
    add(0, 4'h1, 4'hF, 0, 0, 0, 0, 4'h0, "sw_after1");
    add(0, 4'h1, 4'hF, 0, 0, 0, 0, 4'h0, "sw_after2");

    foreach (vecs[i]) begin
      drive_cycle(vecs[i].rst, vecs[i].lvl, vecs[i].en, vecs[i].rdy, vecs[i].clr);
      check({vecs[i].tag, ".valid"},    {7'd0, evt_valid}, {7'd0, vecs[i].ev});
      check({vecs[i].tag, ".id"},       {6'd0, evt_id},    {6'd0, vecs[i].id});
      check({vecs[i].tag, ".overflow"}, {4'd0, overflow},  {4'd0, vecs[i].ovf});
    end

    // burst after reset: rr_ptr=N-1, so all four channels drain as 0,1,2,3, two cycles apart
    drive_cycle(1, 4'hF, 4'hF, 1, 0);
    drive_cycle(0, 4'hF, 4'hF, 1, 0);
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    drive_cycle(0, 4'h0, 4'hF, 1, 0);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 20) begin
      drive_cycle(0, 4'h0, 4'hF, 1, 0);
      cycles++;
      if (evt_valid) begin
        check("burst.id", {6'd0, evt_id}, {6'd0, exp_q.pop_front()});
        check("burst.spacing", 8'(cycles), 8'd1);
        cycles = 0;
        drive_cycle(0, 4'h0, 4'hF, 1, 0);
        check("burst.bubble", {7'd0, evt_valid}, 8'd0);
      end
    end
    check("burst.remaining", 8'(exp_q.size()), 8'd0);
    check("burst.overflow", {4'd0, overflow}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
